// File: rtl/uart_cmd_framer.sv
// Three-byte command framer: HEADER, BTN, ~BTN.
// Accepted frames update a held button vector that times out after HOLD_CYC idle cycles.
module uart_cmd_framer #(
   parameter logic [7:0]  HEADER   = 8'hA5,
   parameter int unsigned HOLD_CYC = 3_240_000,
   parameter int unsigned GAP_CYC  = 108_000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   output logic [6:0] o_btn,
   output logic [6:0] o_btn_rise,
   output logic       o_frame_ok,
   output logic [7:0] o_err_cnt
);

   localparam int HOLD_W = $clog2(HOLD_CYC + 1);
   localparam int GAP_W  = $clog2(GAP_CYC + 1);

   typedef enum logic [1:0] {IDLE, GOT_HDR, GOT_BTN} state_t;

   state_t            state_q;
   logic [6:0]        btn_lat_q;
   logic [6:0]        btn_q;
   logic [6:0]        rise_q;
   logic              ok_q;
   logic [7:0]        err_q;
   logic [HOLD_W-1:0] hold_q;
   logic [GAP_W-1:0]  gap_q;

   logic accept_d;
   logic err_d;
   logic gap_expire_d;
   logic hold_expire_d;

   always_comb begin
      accept_d      = i_valid && (state_q == GOT_BTN) && (i_data == {1'b1, ~btn_lat_q});
      // A byte in the same cycle always pre-empts the gap timeout.
      gap_expire_d  = !i_valid && (state_q != IDLE) && (gap_q == GAP_W'(GAP_CYC - 1));
      hold_expire_d = (btn_q != 7'd0) && (hold_q == HOLD_W'(HOLD_CYC - 1));
      err_d         = 1'b0;
      if (i_valid) begin
         if (state_q == GOT_HDR)
            err_d = i_data[7] && (i_data != HEADER);
         else if (state_q == GOT_BTN)
            err_d = !accept_d;
      end else begin
         err_d = gap_expire_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= IDLE;
         btn_lat_q <= 7'd0;
         btn_q     <= 7'd0;
         rise_q    <= 7'd0;
         ok_q      <= 1'b0;
         err_q     <= 8'd0;
         hold_q    <= '0;
         gap_q     <= '0;
      end else begin
         ok_q   <= accept_d;
         rise_q <= accept_d ? (btn_lat_q & ~btn_q) : 7'd0;

         if (err_d && (err_q != 8'hFF))
            err_q <= err_q + 8'd1;

         // A frame landing on the expiry cycle wins over the clear.
         if (accept_d) begin
            btn_q  <= btn_lat_q;
            hold_q <= '0;
         end else if (hold_expire_d) begin
            btn_q  <= 7'd0;
            hold_q <= '0;
         end else if (btn_q != 7'd0) begin
            hold_q <= hold_q + 1'b1;
         end else begin
            hold_q <= '0;
         end

         if (i_valid || (state_q == IDLE) || gap_expire_d)
            gap_q <= '0;
         else
            gap_q <= gap_q + 1'b1;

         case (state_q)
            IDLE: begin
               if (i_valid && (i_data == HEADER))
                  state_q <= GOT_HDR;
            end
            GOT_HDR: begin
               if (i_valid) begin
                  if (!i_data[7]) begin
                     btn_lat_q <= i_data[6:0];
                     state_q   <= GOT_BTN;
                  end else if (i_data != HEADER) begin
                     state_q <= IDLE;
                  end
               end else if (gap_expire_d) begin
                  state_q <= IDLE;
               end
            end
            GOT_BTN: begin
               if (i_valid) begin
                  if (!accept_d && (i_data == HEADER))
                     state_q <= GOT_HDR;
                  else
                     state_q <= IDLE;
               end else if (gap_expire_d) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_btn      = btn_q;
   assign o_btn_rise = rise_q;
   assign o_frame_ok = ok_q;
   assign o_err_cnt  = err_q;

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Bench for uart_cmd_framer with short hold/gap timers; accepted-frame
// expectations are queued at stimulus time and checked when o_frame_ok fires.
module tb_uart_cmd_framer;

   localparam int HOLD = 20;
   localparam int GAP  = 8;

   logic       clk;
   logic       rst;
   logic [7:0] data;
   logic       valid;
   logic [6:0] btn;
   logic [6:0] btn_rise;
   logic       frame_ok;
   logic [7:0] err_cnt;

   typedef struct {
      logic [6:0] btn;
      logic [6:0] rise;
   } exp_t;

   exp_t       exp_q[$];
   logic [6:0] model_btn;
   int         n_tests;
   int         n_fail;

   uart_cmd_framer #(
      .HEADER  (8'hA5),
      .HOLD_CYC(HOLD),
      .GAP_CYC (GAP)
   ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_data    (data),
      .i_valid   (valid),
      .o_btn     (btn),
      .o_btn_rise(btn_rise),
      .o_frame_ok(frame_ok),
      .o_err_cnt (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: every o_frame_ok pulse must match the oldest queued frame.
   always @(negedge clk) begin
      if (!rst && frame_ok) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected_frame: got btn=%h rise=%h, required no frame", btn, btn_rise);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (btn !== e.btn || btn_rise !== e.rise) begin
               n_fail++;
               $display("FAIL sb_frame: got btn=%h rise=%h, required btn=%h rise=%h",
                        btn, btn_rise, e.btn, e.rise);
            end else begin
               $display("[TB] frame ok btn=%h rise=%h", btn, btn_rise);
            end
         end
      end
      if (!rst && !frame_ok && btn_rise !== 7'd0) begin
         n_tests++;
         n_fail++;
         $display("FAIL sb_stray_rise: got rise=%h without frame_ok, required 00", btn_rise);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      data  = b;
      valid = 1'b1;
      @(posedge clk);
      #1;
      valid = 1'b0;
      data  = 8'h00;
   endtask

   task automatic push_exp(input logic [6:0] nb);
      exp_t e;
      e.btn  = nb;
      e.rise = nb & ~model_btn;
      exp_q.push_back(e);
      model_btn = nb;
   endtask

   task automatic send_good(input logic [6:0] b);
      logic [7:0] bb;
      bb = {1'b0, b};
      send_byte(8'hA5);
      send_byte(bb);
      push_exp(b);
      send_byte(~bb);
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      valid = 1'b0;
      data  = 8'h00;
      model_btn = 7'd0;
      tick(3);
      n_tests++;
      if ({btn, btn_rise, frame_ok, err_cnt} !== 23'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got btn=%h rise=%h ok=%b err=%h, required all 0",
                  btn, btn_rise, frame_ok, err_cnt);
      end
      rst = 1'b0;
      tick(1);
      $display("[TB] reset released");
   endtask

   task automatic test_basic();
      bit held;
      send_good(7'h05);
      n_tests++;
      if (btn !== 7'h05 || btn_rise !== 7'h05 || frame_ok !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_latency1: got btn=%h rise=%h ok=%b, required 05 05 1",
                  btn, btn_rise, frame_ok);
      end
      held = 1'b1;
      for (int i = 1; i < HOLD; i++) begin
         tick(1);
         if (btn !== 7'h05) held = 1'b0;
      end
      n_tests++;
      if (!held) begin
         n_fail++;
         $display("FAIL basic_hold: got btn=%h before %0d cycles, required 05", btn, HOLD);
      end
      tick(1);
      model_btn = 7'd0;
      n_tests++;
      if (btn !== 7'h00) begin
         n_fail++;
         $display("FAIL basic_expire: got btn=%h after %0d cycles, required 00", btn, HOLD);
      end
      $display("[TB] basic frame 05 held %0d cycles", HOLD);
   endtask

   task automatic test_bad_chk();
      logic [7:0] e0;
      e0 = err_cnt;
      send_byte(8'hA5);
      send_byte(8'h05);
      send_byte(8'hFB);
      tick(1);
      n_tests++;
      if (btn !== 7'h00 || err_cnt !== e0 + 8'd1) begin
         n_fail++;
         $display("FAIL bad_chk: got btn=%h err=%h, required btn=00 err=%h", btn, err_cnt, e0 + 8'd1);
      end
      send_good(7'h10);
      n_tests++;
      if (btn !== 7'h10 || err_cnt !== e0 + 8'd1) begin
         n_fail++;
         $display("FAIL after_bad_chk: got btn=%h err=%h, required btn=10 err=%h", btn, err_cnt, e0 + 8'd1);
      end
      $display("[TB] bad checksum rejected, recovery frame 10");
   endtask

   task automatic test_resync();
      logic [7:0] e0;
      e0 = err_cnt;
      send_byte(8'hA5);
      send_good(7'h03);
      n_tests++;
      if (btn !== 7'h03 || err_cnt !== e0) begin
         n_fail++;
         $display("FAIL resync: got btn=%h err=%h, required btn=03 err=%h", btn, err_cnt, e0);
      end
      $display("[TB] double header resync frame 03");
   endtask

   task automatic test_gap();
      logic [7:0] e0;
      tick(HOLD + 5);
      model_btn = 7'd0;
      e0 = err_cnt;
      send_byte(8'hA5);
      tick(GAP);
      send_byte(8'h03);
      send_byte(8'hFC);
      tick(1);
      n_tests++;
      if (btn !== 7'h00 || err_cnt !== e0 + 8'd1) begin
         n_fail++;
         $display("FAIL gap_timeout: got btn=%h err=%h, required btn=00 err=%h", btn, err_cnt, e0 + 8'd1);
      end
      // One cycle short of the timeout: the arriving byte must win.
      send_byte(8'hA5);
      tick(GAP - 1);
      send_byte(8'h03);
      push_exp(7'h03);
      send_byte(8'hFC);
      n_tests++;
      if (btn !== 7'h03 || err_cnt !== e0 + 8'd1) begin
         n_fail++;
         $display("FAIL gap_edge: got btn=%h err=%h, required btn=03 err=%h", btn, err_cnt, e0 + 8'd1);
      end
      tick(HOLD + 5);
      model_btn = 7'd0;
      $display("[TB] gap timeout and gap boundary");
   endtask

   task automatic test_back_to_back();
      int  rises;
      bit  held;
      rises = 0;
      held  = 1'b1;
      for (int f = 0; f < 7; f++) begin
         send_good(7'h05);
         if (btn_rise !== 7'd0) rises++;
         if (btn !== 7'h05) held = 1'b0;
         for (int i = 0; i < 12; i++) begin
            tick(1);
            if (btn !== 7'h05) held = 1'b0;
         end
      end
      n_tests++;
      if (!held || rises != 1) begin
         n_fail++;
         $display("FAIL repeat_frames: got held=%b rises=%0d, required held=1 rises=1", held, rises);
      end
      tick(HOLD + 5);
      model_btn = 7'd0;
      $display("[TB] repeated frame 05 x7, rises=%0d", rises);
   endtask

   task automatic test_saturate();
      for (int f = 0; f < 300; f++) begin
         send_byte(8'hA5);
         send_byte(8'h05);
         send_byte(8'hFB);
      end
      tick(1);
      n_tests++;
      if (err_cnt !== 8'hFF) begin
         n_fail++;
         $display("FAIL err_saturate: got err=%h, required FF", err_cnt);
      end
      $display("[TB] 300 bad frames, err=%h", err_cnt);
   endtask

   task automatic test_reset_mid();
      send_byte(8'hA5);
      send_byte(8'h05);
      rst   = 1'b1;
      data  = 8'hFA;
      valid = 1'b1;
      tick(2);
      valid = 1'b0;
      n_tests++;
      if ({btn, btn_rise, frame_ok, err_cnt} !== 23'd0) begin
         n_fail++;
         $display("FAIL reset_mid: got btn=%h rise=%h ok=%b err=%h, required all 0",
                  btn, btn_rise, frame_ok, err_cnt);
      end
      rst = 1'b0;
      model_btn = 7'd0;
      tick(1);
      send_byte(8'hFA);
      send_byte(8'h05);
      send_byte(8'hFA);
      tick(1);
      n_tests++;
      if (btn !== 7'h00 || err_cnt !== 8'h00) begin
         n_fail++;
         $display("FAIL post_reset_idle: got btn=%h err=%h, required 00 00", btn, err_cnt);
      end
      send_good(7'h22);
      n_tests++;
      if (btn !== 7'h22 || err_cnt !== 8'h00) begin
         n_fail++;
         $display("FAIL post_reset_frame: got btn=%h err=%h, required 22 00", btn, err_cnt);
      end
      tick(2);
      $display("[TB] mid-frame reset discarded partial frame");
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_basic();
      test_bad_chk();
      test_resync();
      test_gap();
      test_back_to_back();
      test_saturate();
      test_reset_mid();
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: got %0d frames outstanding, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
